uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_pkg.sv | 14 +
 rtl/uart_tx_fifo_if.sv | 25 ++
 rtl/uart_fifo_mem.sv | 64 ++++++
 rtl/uart_tx_fifo.sv | 106 ++++++++++
 tb/tb_uart_tx_fifo.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART package: FSM state encoding and default sizing constants
// used by the UART transmit and receive blocks.
package uart_tx_fifo_pkg;

    localparam int DEF_DEPTH_LOG2   = 4;
    localparam int DEF_BUSY_TIMEOUT = 63;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_IDLE = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bus-side and transmitter-side signals of the UART transmit FIFO.
// The master modport is the environment; the slave modport is the FIFO.
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = uart_tx_fifo_pkg::DEF_DEPTH_LOG2
);
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  tx_idle;
    logic                  tx_request;
    logic [7:0]            tx_data;

    modport master (
        output wr_en, wr_data, tx_idle,
        input  full, empty, count, overflow, tx_request, tx_data
    );

    modport slave (
        input  wr_en, wr_data, tx_idle,
        output full, empty, count, overflow, tx_request, tx_data
    );
endinterface

// File: rtl/uart_fifo_mem.sv
// Circular byte buffer with synchronous write and combinational head read;
// shared by the UART transmit and receive paths.
module uart_fifo_mem
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                push,
    input  logic                pop,
    input  logic [7:0]          wr_data,
    output logic [7:0]          head,
    output logic [DEPTH_LOG2:0] count,
    output logic                full,
    output logic                empty,
    output logic                dropped
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  do_push, do_pop;

    // A full buffer still accepts a byte when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dropped = push && !do_push;

    assign head  = mem[rd_ptr];
    assign count = count_q;
    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);

    // NOTE: the storage array has no reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit FIFO: buffers bus bytes and launches them one at a time to
// the transmitter. Optional flush input when UART_TX_FIFO_FLUSH_EN is defined.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2   = DEF_DEPTH_LOG2,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic clk_bus,
    input  logic rst,
`ifdef UART_TX_FIFO_FLUSH_EN
    input  logic flush,
`endif
    uart_tx_fifo_if.slave bus
);
    localparam int TIMER_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(BUSY_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);

    tx_state_e          state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               launch;
    logic               clear;
    logic               dropped;
    logic [7:0]         head;
    logic               overflow_q;
    logic               tx_request_q;
    logic [7:0]         tx_data_q;

`ifdef UART_TX_FIFO_FLUSH_EN
    assign clear = flush;
`else
    assign clear = 1'b0;
`endif

    uart_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk     (clk_bus),
        .rst     (rst),
        .clear   (clear),
        .push    (bus.wr_en),
        .pop     (launch),
        .wr_data (bus.wr_data),
        .head    (head),
        .count   (bus.count),
        .full    (bus.full),
        .empty   (bus.empty),
        .dropped (dropped)
    );

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        launch  = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                // count is registered, so a byte pushed this cycle launches no earlier than the next.
                if (!bus.empty && bus.tx_idle) begin
                    launch  = 1'b1;
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!bus.tx_idle) begin
                    state_d = WAIT_IDLE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            WAIT_IDLE: begin
                if (bus.tx_idle) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_bus) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            tx_request_q <= 1'b0;
            tx_data_q    <= 8'h00;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            tx_request_q <= launch;
            if (launch) tx_data_q <= head;
            if (clear) begin
                overflow_q <= 1'b0;
            end else if (dropped) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.tx_request = tx_request_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo: reset, single launch, paced sequence,
// overflow, full-with-launch, busy timeout and mid-transfer reset.
module tb_uart_tx_fifo;

    localparam int DL = 4;
    localparam int TO = 63;

    logic clk_bus = 1'b0;
    logic rst     = 1'b1;
`ifdef UART_TX_FIFO_FLUSH_EN
    logic flush   = 1'b0;
`endif

    int vectors     = 0;
    int miscompares = 0;

    uart_tx_fifo_if #(.DEPTH_LOG2(DL)) bus ();

    uart_tx_fifo #(
        .DEPTH_LOG2   (DL),
        .BUSY_TIMEOUT (TO)
    ) dut (
        .clk_bus (clk_bus),
        .rst     (rst),
`ifdef UART_TX_FIFO_FLUSH_EN
        .flush   (flush),
`endif
        .bus     (bus)
    );

    always #5 clk_bus = ~clk_bus;

    task automatic tick();
        @(posedge clk_bus);
        #1;
    endtask

    task automatic finish_tx();
        bus.tx_idle = 1'b0;
        tick();
        tick();
        bus.tx_idle = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.wr_en = 1'b0;
        bus.wr_data = 8'h00;
        bus.tx_idle = 1'b1;
        tick();
        tick();
        vectors++; if (bus.count !== 5'd0)      begin miscompares++; $display("FAIL reset_count got=%0d want=0", bus.count); end
        vectors++; if (bus.empty !== 1'b1)      begin miscompares++; $display("FAIL reset_empty got=%b want=1", bus.empty); end
        vectors++; if (bus.full !== 1'b0)       begin miscompares++; $display("FAIL reset_full got=%b want=0", bus.full); end
        vectors++; if (bus.overflow !== 1'b0)   begin miscompares++; $display("FAIL reset_overflow got=%b want=0", bus.overflow); end
        vectors++; if (bus.tx_request !== 1'b0) begin miscompares++; $display("FAIL reset_tx_request got=%b want=0", bus.tx_request); end
        vectors++; if (bus.tx_data !== 8'h00)   begin miscompares++; $display("FAIL reset_tx_data got=%0h want=0", bus.tx_data); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bus.tx_idle = 1'b1;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h41;
        tick();
        bus.wr_en = 1'b0;
        vectors++; if (bus.count !== 5'd1)      begin miscompares++; $display("FAIL single_count_after_push got=%0d want=1", bus.count); end
        vectors++; if (bus.tx_request !== 1'b0) begin miscompares++; $display("FAIL single_no_same_cycle got=%b want=0", bus.tx_request); end
        tick();
        vectors++; if (bus.tx_request !== 1'b1) begin miscompares++; $display("FAIL single_request got=%b want=1", bus.tx_request); end
        vectors++; if (bus.tx_data !== 8'h41)   begin miscompares++; $display("FAIL single_data got=%0h want=41", bus.tx_data); end
        vectors++; if (bus.count !== 5'd0)      begin miscompares++; $display("FAIL single_count_after_pop got=%0d want=0", bus.count); end
        tick();
        vectors++; if (bus.tx_request !== 1'b0) begin miscompares++; $display("FAIL single_pulse_width got=%b want=0", bus.tx_request); end
        finish_tx();
    endtask

    // Transmitter model: tx_idle falls 3 cycles after each request and rises 20 cycles later.
    task automatic test_back_to_back();
        logic [7:0] exp_q [3] = '{8'h01, 8'h02, 8'h03};
        logic [7:0] held = 8'h00;
        int since = -1;
        int n_req = 0;
        for (int k = 0; k < 100; k++) begin
            bus.wr_en   = (k < 3);
            bus.wr_data = 8'(k + 1);
            bus.tx_idle = !(since >= 3 && since < 23);
            tick();
            if (since >= 0) since++;
            if (bus.tx_request === 1'b1) begin
                vectors++;
                if (n_req >= 3) begin
                    miscompares++; $display("FAIL b2b_extra_request data=%0h at k=%0d", bus.tx_data, k);
                end else begin
                    if (bus.tx_data !== exp_q[n_req]) begin
                        miscompares++; $display("FAIL b2b_order got=%0h want=%0h", bus.tx_data, exp_q[n_req]);
                    end
                    vectors++;
                    if (n_req == 0 && k != 1) begin
                        miscompares++; $display("FAIL b2b_first_timing got_k=%0d want_k=1", k);
                    end else if (n_req > 0 && since != 25) begin
                        miscompares++; $display("FAIL b2b_gap got=%0d want=25", since);
                    end
                end
                held  = bus.tx_data;
                since = 0;
                n_req++;
            end else if (n_req > 0) begin
                vectors++;
                if (bus.tx_data !== held) begin
                    miscompares++; $display("FAIL b2b_data_hold got=%0h want=%0h", bus.tx_data, held);
                end
            end
        end
        bus.wr_en = 1'b0;
        vectors++; if (n_req != 3) begin miscompares++; $display("FAIL b2b_request_count got=%0d want=3", n_req); end
    endtask

    task automatic test_overflow();
        bus.tx_idle = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(8'h10 + i);
            tick();
            if (i == 14) begin
                vectors++; if (bus.full !== 1'b0)  begin miscompares++; $display("FAIL ovf_full_at_15 got=%b want=0", bus.full); end
                vectors++; if (bus.count !== 5'd15) begin miscompares++; $display("FAIL ovf_count_at_15 got=%0d want=15", bus.count); end
            end else if (i == 15) begin
                vectors++; if (bus.full !== 1'b1)     begin miscompares++; $display("FAIL ovf_full_at_16 got=%b want=1", bus.full); end
                vectors++; if (bus.count !== 5'd16)   begin miscompares++; $display("FAIL ovf_count_at_16 got=%0d want=16", bus.count); end
                vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_early_flag got=%b want=0", bus.overflow); end
            end else if (i == 16) begin
                vectors++; if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got=%b want=1", bus.overflow); end
                vectors++; if (bus.count !== 5'd16)   begin miscompares++; $display("FAIL ovf_count_at_17 got=%0d want=16", bus.count); end
                vectors++; if (bus.full !== 1'b1)     begin miscompares++; $display("FAIL ovf_full_at_17 got=%b want=1", bus.full); end
            end
        end
        bus.wr_en = 1'b0;
        tick();
    endtask

    task automatic test_full_launch();
        bus.tx_idle = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hAA;
        tick();
        bus.wr_en = 1'b0;
        vectors++; if (bus.tx_request !== 1'b1) begin miscompares++; $display("FAIL full_launch_request got=%b want=1", bus.tx_request); end
        vectors++; if (bus.tx_data !== 8'h10)   begin miscompares++; $display("FAIL full_launch_data got=%0h want=10", bus.tx_data); end
        vectors++; if (bus.count !== 5'd16)     begin miscompares++; $display("FAIL full_launch_count got=%0d want=16", bus.count); end
        vectors++; if (bus.overflow !== 1'b1)   begin miscompares++; $display("FAIL full_launch_sticky got=%b want=1", bus.overflow); end
    endtask

    // tx_idle never falls after the request above, so only the busy timeout can release the FSM.
    task automatic test_timeout();
        int found = 0;
        bus.tx_idle = 1'b1;
        for (int k = 1; k <= 100 && found == 0; k++) begin
            tick();
            if (bus.tx_request === 1'b1) begin
                found = k;
            end
        end
        vectors++; if (found != 64)           begin miscompares++; $display("FAIL timeout_gap got=%0d want=64", found); end
        vectors++; if (bus.tx_data !== 8'h11) begin miscompares++; $display("FAIL timeout_next_data got=%0h want=11", bus.tx_data); end
        vectors++; if (bus.count !== 5'd15)   begin miscompares++; $display("FAIL timeout_count got=%0d want=15", bus.count); end
    endtask

    task automatic test_reset_mid();
        int n_req = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.tx_idle = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(8'h60 + i);
            tick();
        end
        bus.wr_en   = 1'b0;
        bus.tx_idle = 1'b1;
        tick();
        vectors++; if (bus.tx_request !== 1'b1) begin miscompares++; $display("FAIL rmid_launch got=%b want=1", bus.tx_request); end
        vectors++; if (bus.tx_data !== 8'h60)   begin miscompares++; $display("FAIL rmid_launch_data got=%0h want=60", bus.tx_data); end
        bus.tx_idle = 1'b0;
        tick();
        vectors++; if (bus.count !== 5'd5)      begin miscompares++; $display("FAIL rmid_queued got=%0d want=5", bus.count); end
        rst = 1'b1;
        tick();
        vectors++; if (bus.count !== 5'd0)      begin miscompares++; $display("FAIL rmid_count got=%0d want=0", bus.count); end
        vectors++; if (bus.empty !== 1'b1)      begin miscompares++; $display("FAIL rmid_empty got=%b want=1", bus.empty); end
        vectors++; if (bus.tx_data !== 8'h00)   begin miscompares++; $display("FAIL rmid_tx_data got=%0h want=0", bus.tx_data); end
        rst = 1'b0;
        bus.tx_idle = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.tx_request === 1'b1) n_req++;
        end
        vectors++; if (n_req != 0) begin miscompares++; $display("FAIL rmid_spurious_requests got=%0d want=0", n_req); end
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h5A;
        tick();
        bus.wr_en = 1'b0;
        vectors++; if (bus.tx_request !== 1'b0) begin miscompares++; $display("FAIL rmid_no_same_cycle got=%b want=0", bus.tx_request); end
        tick();
        vectors++; if (bus.tx_request !== 1'b1) begin miscompares++; $display("FAIL rmid_new_request got=%b want=1", bus.tx_request); end
        vectors++; if (bus.tx_data !== 8'h5A)   begin miscompares++; $display("FAIL rmid_new_data got=%0h want=5a", bus.tx_data); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_launch();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
